// File: rtl/cordic_cos_accumulator.sv
// rtl/cordic_cos_accumulator.sv - pipelined CORDIC cosine feeding a running accumulator
// Optional macro CORDIC_ACC_SAT_EN: saturating accumulator and READ instead of wrap.
module cordic_cos_accumulator #(
    parameter int WIDTH     = 32,
    parameter int ITER      = 16,
    parameter int ACC_GUARD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             start,
    input  logic [1:0]       n,
    input  logic [WIDTH-1:0] x_one,
    input  logic [WIDTH-1:0] x_two,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);
    localparam int ACC_W = WIDTH + ACC_GUARD;

    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_GO    = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    localparam logic signed [WIDTH-1:0] P_ONE  = {2'b01, {(WIDTH-2){1'b0}}};
    localparam logic signed [WIDTH-1:0] P_MONE = {2'b11, {(WIDTH-2){1'b0}}};
    localparam logic signed [31:0]      K_Q30  = 32'sd652032874;
    localparam logic signed [31:0]      K_SH   = K_Q30 >>> (32 - WIDTH);
    localparam logic signed [WIDTH-1:0] P_K    = K_SH[WIDTH-1:0];

    // atan(2^-idx) in Q2.30, rescaled to the working width
    function automatic logic signed [WIDTH-1:0] atan_tab(input int idx);
        logic signed [31:0] q;
        logic signed [31:0] s;
        case (idx)
            0:       q = 32'sd843314857;
            1:       q = 32'sd497837829;
            2:       q = 32'sd263043837;
            3:       q = 32'sd133525159;
            4:       q = 32'sd67021687;
            5:       q = 32'sd33543516;
            6:       q = 32'sd16775851;
            7:       q = 32'sd8388437;
            8:       q = 32'sd4194283;
            9:       q = 32'sd2097149;
            10:      q = 32'sd1048576;
            default: q = (idx > 30) ? 32'sd0 : (32'sd1 <<< (30 - idx));
        endcase
        s = q >>> (32 - WIDTH);
        return s[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] r_x [0:ITER];
    logic signed [WIDTH-1:0] r_y [0:ITER];
    logic signed [WIDTH-1:0] r_z [0:ITER];
    logic signed [WIDTH-1:0] w_x [1:ITER];
    logic signed [WIDTH-1:0] w_y [1:ITER];
    logic signed [WIDTH-1:0] w_z [1:ITER];
    logic [ITER:0]           r_v;
    logic                    r_vf;
    logic [WIDTH-1:0]        r_xf;

    logic [ACC_W-1:0]        r_acc;
    logic [WIDTH-1:0]        r_result;
    logic                    r_done;
    logic                    r_busy;
    logic                    r_pend;
    logic                    r_pend_read;
    logic                    r_nop;

    logic signed [WIDTH-1:0] w_ang;
    logic                    w_accept;
    logic                    w_go;
    logic                    w_empty;
    logic [ACC_W-1:0]        w_xf_ext;
    logic [ACC_W-1:0]        w_acc_next;
    logic [WIDTH-1:0]        w_read;
    logic                    w_unused;

    assign w_unused = ^{x_two, r_y[ITER], r_z[ITER]};

    assign w_ang = ($signed(x_one) > P_ONE)  ? P_ONE  :
                   ($signed(x_one) < P_MONE) ? P_MONE : $signed(x_one);

    assign w_accept = start & ~r_busy;
    assign w_go     = w_accept & (n == OP_GO);
    assign w_empty  = ~(|r_v) & ~r_vf;
    assign w_xf_ext = {{ACC_GUARD{r_xf[WIDTH-1]}}, r_xf};

`ifdef CORDIC_ACC_SAT_EN
    logic [ACC_W:0]       w_sum_wide;
    logic [ACC_W-WIDTH:0] w_hi;
    logic                 w_in_range;

    assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_xf_ext[ACC_W-1], w_xf_ext};
    assign w_acc_next = (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) ?
                        (w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) :
                        w_sum_wide[ACC_W-1:0];
    assign w_hi       = r_acc[ACC_W-1:WIDTH-1];
    assign w_in_range = (&w_hi) | ~(|w_hi);
    assign w_read     = w_in_range ? r_acc[WIDTH-1:0] :
                        (r_acc[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign w_acc_next = r_acc + w_xf_ext;
    assign w_read     = r_acc[WIDTH-1:0];
`endif

    // One rotation per stage; direction follows the sign of the residual angle
    always_comb begin
        for (int i = 0; i < ITER; i++) begin
            if (!r_z[i][WIDTH-1]) begin
                w_x[i+1] = r_x[i] - (r_y[i] >>> i);
                w_y[i+1] = r_y[i] + (r_x[i] >>> i);
                w_z[i+1] = r_z[i] - atan_tab(i);
            end else begin
                w_x[i+1] = r_x[i] + (r_y[i] >>> i);
                w_y[i+1] = r_y[i] - (r_x[i] >>> i);
                w_z[i+1] = r_z[i] + atan_tab(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            r_x[0] <= P_K;
            r_y[0] <= '0;
            r_z[0] <= w_ang;
            for (int i = 1; i <= ITER; i++) begin
                r_x[i] <= w_x[i];
                r_y[i] <= w_y[i];
                r_z[i] <= w_z[i];
            end
            r_xf <= r_x[ITER];
        end
    end

    // Barriers complete only once every valid bit is clear, so they never meet a GO done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_vf        <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_read <= 1'b0;
            r_nop       <= 1'b0;
        end else if (clk_en) begin
            r_v    <= {r_v[ITER-1:0], w_go};
            r_vf   <= r_v[ITER];
            r_done <= 1'b0;
            if (r_vf) begin
                r_acc    <= w_acc_next;
                r_result <= r_xf;
                r_done   <= 1'b1;
            end else if (r_pend && w_empty) begin
                r_pend <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
                if (r_pend_read) begin
                    r_result <= w_read;
                end else begin
                    r_acc    <= '0;
                    r_result <= '0;
                end
            end else if (r_nop) begin
                r_nop    <= 1'b0;
                r_result <= '0;
                r_done   <= 1'b1;
            end
            if (w_accept) begin
                case (n)
                    OP_CLEAR, OP_READ: begin
                        r_pend      <= 1'b1;
                        r_pend_read <= (n == OP_READ);
                        r_busy      <= |r_v;
                    end
                    OP_NOP:  r_nop <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign result = r_result;
    assign done   = r_done & clk_en;
    assign busy   = r_busy;
endmodule

// File: tb/tb_cordic_cos_accumulator.sv
// tb/tb_cordic_cos_accumulator.sv - directed scoreboard bench for cordic_cos_accumulator
module tb_cordic_cos_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] x_one;
    logic [31:0] x_two;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        string       tag;
        int          due;
        logic [31:0] val;
        int          tol;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_cos_accumulator #(.WIDTH(32), .ITER(16), .ACC_GUARD(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .x_one  (x_one),
        .x_two  (x_two),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    function automatic bit near(input logic [31:0] a, input logic [31:0] b, input int tol);
        logic signed [31:0] d;
        d = a - b;
        return (d <= tol) && (d >= -tol);
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                assert (done === 1'b0) else begin
                    failures++;
                    $error("FAIL unexpected_done observed=%0b expected=0 cyc=%0d", done, cyc);
                end
            end else begin
                cur = sb.pop_front();
                checks += 2;
                assert (cyc === cur.due) else begin
                    failures++;
                    $error("FAIL %s_cycle observed=%0d expected=%0d", cur.tag, cyc, cur.due);
                end
                assert (near(result, cur.val, cur.tol) === 1'b1) else begin
                    failures++;
                    $error("FAIL %s_result observed=%0d expected=%0d", cur.tag, result, cur.val);
                end
            end
        end
    end

    task automatic push(input string tag, input int due, input logic [31:0] val, input int tol);
        exp_t e;
        e.tag = tag;
        e.due = due;
        e.val = val;
        e.tol = tol;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] x, output int e);
        start = 1'b1;
        n     = op;
        x_one = x;
        e     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        n     = 2'd3;
    endtask

    task automatic wait_drain(input int lim);
        int k;
        k = 0;
        while (sb.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        checks++;
        assert (sb.size() === 0) else begin
            failures++;
            $error("FAIL drain observed=%0d expected=0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        int e;
        int e2;
        int e3;
        rst    = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        n      = 2'd3;
        x_one  = '0;
        x_two  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        checks++;
        assert (result === 32'h0) else begin
            failures++;
            $error("FAIL reset_result observed=%0h expected=0", result);
        end
        rst = 1'b0;
        @(negedge clk);

        issue(2'd2, 32'h0, e);
        push("read_empty", e + 1, 32'h0, 0);
        check_bit("busy_empty", busy, 1'b0);
        wait_drain(10);

        issue(2'd1, 32'h0, e);
        push("go_zero", e + 18, 32'h40000000, 65536);
        wait_drain(40);

        issue(2'd0, 32'h0, e);
        push("clear_a", e + 1, 32'h0, 0);
        wait_drain(10);
        issue(2'd1, 32'h20000000, e);
        push("go_pos", e + 18, 32'd942297102, 65536);
        issue(2'd1, 32'hE0000000, e2);
        push("go_neg", e2 + 18, 32'd942297102, 65536);
        issue(2'd2, 32'h0, e3);
        push("read_pair", e3 + 18, 32'd1884594204, 131072);
        check_bit("busy_barrier", busy, 1'b1);
        issue(2'd2, 32'h0, e);
        check_bit("busy_hold", busy, 1'b1);
        wait_drain(40);
        check_bit("busy_fall", busy, 1'b0);

        issue(2'd1, 32'h0, e);
        push("go_stall", e + 23, 32'h40000000, 65536);
        repeat (3) @(negedge clk);
        clk_en = 1'b0;
        start  = 1'b1;
        n      = 2'd1;
        x_one  = 32'h10000000;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
        start  = 1'b0;
        n      = 2'd3;
        wait_drain(50);

        issue(2'd0, 32'h0, e);
        push("clear_b", e + 1, 32'h0, 0);
        wait_drain(10);
        for (int i = 0; i < 3; i++) begin
            issue(2'd1, 32'h0, e);
            push("go_one", e + 18, 32'h40000000, 65536);
        end
        issue(2'd2, 32'h0, e);
`ifdef CORDIC_ACC_SAT_EN
        push("read_sat", e + 18, 32'h7FFFFFFF, 0);
`else
        push("read_wrap", e + 18, 32'hC0000000, 196608);
`endif
        wait_drain(40);

        issue(2'd1, 32'h10000000, e);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        repeat (30) @(negedge clk);
        issue(2'd2, 32'h0, e);
        push("read_after_rst", e + 1, 32'h0, 0);
        wait_drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
